// File: rtl/req_issuer.sv
// Requester side of the priority selector: counts client events, drives req/en,
// retires one pending request per accepted one-hot grant and acks the client.
module req_issuer #(
   parameter int N     = 4,
   parameter int CNT_W = 3,
   parameter int GAP   = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] evt,
   output logic [N-1:0] req,
   output logic         en,
   input  logic [N-1:0] gnt,
   output logic [N-1:0] ack,
   output logic [N-1:0] ovf,
   output logic         gnt_err
);

   localparam logic [CNT_W-1:0] MAX_CNT = '1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARB,
      S_GAP
   } state_t;

   state_t                  r_state;
   logic                    r_en;
   logic [GAP_W-1:0]        r_gapCnt;
   logic [N-1:0][CNT_W-1:0] r_cnt;
   logic [N-1:0]            r_ack;
   logic [N-1:0]            r_ovf;
   logic                    r_gntErr;

   logic [N-1:0][CNT_W-1:0] w_cntNext;
   logic [N-1:0]            w_ovfSet;
   logic [N-1:0]            w_req;
   logic [N-1:0]            w_reqNext;
   logic [N-1:0]            w_dec;
   logic                    w_oneHot;
   logic                    w_accept;
   logic                    w_illegal;

   // A grant only counts when the selector was enabled, it is a single bit,
   // and that client actually has something pending; anything else nonzero is an error.
   always_comb begin
      w_oneHot  = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
      w_accept  = r_en && w_oneHot && ((gnt & w_req) != '0);
      w_illegal = (gnt != '0) && !w_accept;
      w_dec     = w_accept ? gnt : '0;
   end

   always_comb begin
      w_cntNext = r_cnt;
      w_ovfSet  = '0;
      w_req     = '0;
      w_reqNext = '0;
      for (int i = 0; i < N; i++) begin
         if (evt[i] && !w_dec[i]) begin
            if (r_cnt[i] == MAX_CNT) begin
               w_ovfSet[i] = 1'b1;
            end else begin
               w_cntNext[i] = r_cnt[i] + 1'b1;
            end
         end else if (w_dec[i] && !evt[i]) begin
            w_cntNext[i] = r_cnt[i] - 1'b1;
         end
         w_req[i]     = (r_cnt[i] != '0);
         w_reqNext[i] = (w_cntNext[i] != '0);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_ack    <= '0;
         r_ovf    <= '0;
         r_gntErr <= 1'b0;
      end else begin
         r_cnt    <= w_cntNext;
         r_ack    <= w_dec;
         r_ovf    <= r_ovf | w_ovfSet;
         r_gntErr <= r_gntErr | w_illegal;
      end
   end

   // en is registered alongside the state so it is high exactly while in ARB.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_en     <= 1'b0;
         r_gapCnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req != '0) begin
                  r_state <= S_ARB;
                  r_en    <= 1'b1;
               end
            end
            S_ARB: begin
               if (w_accept) begin
                  if (GAP > 0) begin
                     r_state  <= S_GAP;
                     r_en     <= 1'b0;
                     r_gapCnt <= GAP_W'(GAP - 1);
                  end else if (w_reqNext == '0) begin
                     r_state <= S_IDLE;
                     r_en    <= 1'b0;
                  end
               end else if (w_reqNext == '0) begin
                  r_state <= S_IDLE;
                  r_en    <= 1'b0;
               end
            end
            S_GAP: begin
               if (r_gapCnt == '0) begin
                  if (w_req != '0) begin
                     r_state <= S_ARB;
                     r_en    <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_gapCnt <= r_gapCnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_en    <= 1'b0;
            end
         endcase
      end
   end

   assign req     = w_req;
   assign en      = r_en;
   assign ack     = r_ack;
   assign ovf     = r_ovf;
   assign gnt_err = r_gntErr;

endmodule

// File: tb/tb_req_issuer.sv
// Directed bench for req_issuer (N=4, CNT_W=3, GAP=2) with hand-computed expectations.
module tb_req_issuer;

   logic       clock;
   logic       reset;
   logic [3:0] evt;
   logic [3:0] gnt;
   logic [3:0] req;
   logic       en;
   logic [3:0] ack;
   logic [3:0] ovf;
   logic       gnt_err;

   int total;
   int bad;
   int acks;

   req_issuer #(
      .N(4),
      .CNT_W(3),
      .GAP(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .evt(evt),
      .req(req),
      .en(en),
      .gnt(gnt),
      .ack(ack),
      .ovf(ovf),
      .gnt_err(gnt_err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
   task automatic applyStimulus(input logic [3:0] e, input logic [3:0] g);
      evt = e;
      gnt = g;
      @(posedge clock);
      #1;
      evt = 4'b0000;
      gnt = 4'b0000;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Reset, post events, and wait until the FSM has reached ARB.
   task automatic setupArb(input logic [3:0] e);
      doReset();
      applyStimulus(e, 4'b0000);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("setup_en", {3'b000, en}, 4'b0001);
   endtask

   // Initial block drives stimulus tests 1 to 5 sequentially.
   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      evt   = 4'b0000;
      gnt   = 4'b0000;
      #3;
      checkOutput("rst_req", req, 4'b0000);
      checkOutput("rst_en", {3'b000, en}, 4'b0000);
      checkOutput("rst_ack", ack, 4'b0000);
      checkOutput("rst_ovf", ovf, 4'b0000);
      checkOutput("rst_err", {3'b000, gnt_err}, 4'b0000);
      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] test 1: single request and grant");
      applyStimulus(4'b0010, 4'b0000);
      checkOutput("t1_req_t1", req, 4'b0010);
      checkOutput("t1_en_t1", {3'b000, en}, 4'b0000);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t1_en_t2", {3'b000, en}, 4'b0001);
      applyStimulus(4'b0000, 4'b0010);
      checkOutput("t1_ack_t3", ack, 4'b0010);
      checkOutput("t1_req_t3", req, 4'b0000);
      checkOutput("t1_en_t3", {3'b000, en}, 4'b0000);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t1_ack_t4", ack, 4'b0000);
      applyStimulus(4'b0000, 4'b0000);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t1_en_idle", {3'b000, en}, 4'b0000);
      checkOutput("t1_err", {3'b000, gnt_err}, 4'b0000);

      $display("[TB] test 2: saturation and overflow");
      for (int k = 0; k < 7; k++) applyStimulus(4'b0001, 4'b0000);
      checkOutput("t2_req", req, 4'b0001);
      checkOutput("t2_ovf_7", ovf, 4'b0000);
      checkOutput("t2_en", {3'b000, en}, 4'b0001);
      applyStimulus(4'b0001, 4'b0000);
      checkOutput("t2_ovf_8", ovf, 4'b0001);
      checkOutput("t2_err_idlegnt", {3'b000, gnt_err}, 4'b0000);
      applyStimulus(4'b0001, 4'b0001);
      checkOutput("t2_ack_incdec", ack, 4'b0001);
      checkOutput("t2_ovf_incdec", ovf, 4'b0001);
      acks = 0;
      for (int k = 0; k < 40 && req[0]; k++) begin
         applyStimulus(4'b0000, en ? 4'b0001 : 4'b0000);
         if (ack[0]) acks++;
      end
      checkOutput("t2_drain_acks", 4'(acks), 4'd7);
      checkOutput("t2_drain_req", req, 4'b0000);
      checkOutput("t2_drain_err", {3'b000, gnt_err}, 4'b0000);

      $display("[TB] test 3: idle gap between grants");
      doReset();
      applyStimulus(4'b1010, 4'b0000);
      checkOutput("t3_req", req, 4'b1010);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t3_en_a", {3'b000, en}, 4'b0001);
      applyStimulus(4'b0000, 4'b1000);
      checkOutput("t3_en_b", {3'b000, en}, 4'b0000);
      checkOutput("t3_ack_hi", ack, 4'b1000);
      checkOutput("t3_req_b", req, 4'b0010);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t3_en_c", {3'b000, en}, 4'b0000);
      checkOutput("t3_ack_c", ack, 4'b0000);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t3_en_d", {3'b000, en}, 4'b0001);
      applyStimulus(4'b0000, 4'b0010);
      checkOutput("t3_ack_lo", ack, 4'b0010);
      checkOutput("t3_req_e", req, 4'b0000);

      $display("[TB] test 4: illegal grants");
      setupArb(4'b0011);
      applyStimulus(4'b0000, 4'b0110);
      checkOutput("t4a_err", {3'b000, gnt_err}, 4'b0001);
      checkOutput("t4a_ack", ack, 4'b0000);
      checkOutput("t4a_req", req, 4'b0011);
      checkOutput("t4a_en", {3'b000, en}, 4'b0001);

      setupArb(4'b0011);
      applyStimulus(4'b0000, 4'b0100);
      checkOutput("t4b_err", {3'b000, gnt_err}, 4'b0001);
      checkOutput("t4b_ack", ack, 4'b0000);
      checkOutput("t4b_req", req, 4'b0011);

      setupArb(4'b0011);
      applyStimulus(4'b0000, 4'b0010);
      checkOutput("t4c_ack_ok", ack, 4'b0010);
      checkOutput("t4c_err_ok", {3'b000, gnt_err}, 4'b0000);
      applyStimulus(4'b0000, 4'b0001);
      checkOutput("t4c_err", {3'b000, gnt_err}, 4'b0001);
      checkOutput("t4c_ack", ack, 4'b0000);
      checkOutput("t4c_req", req, 4'b0001);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t4c_en", {3'b000, en}, 4'b0001);

      $display("[TB] test 5: asynchronous reset mid-gap");
      doReset();
      applyStimulus(4'b1101, 4'b0000);
      applyStimulus(4'b1101, 4'b0000);
      applyStimulus(4'b1000, 4'b0010);
      checkOutput("t5_err_pre", {3'b000, gnt_err}, 4'b0001);
      applyStimulus(4'b0000, 4'b0001);
      checkOutput("t5_ack_pre", ack, 4'b0001);
      checkOutput("t5_req_pre", req, 4'b1101);
      checkOutput("t5_en_pre", {3'b000, en}, 4'b0000);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t5_req_rst", req, 4'b0000);
      checkOutput("t5_en_rst", {3'b000, en}, 4'b0000);
      checkOutput("t5_ack_rst", ack, 4'b0000);
      checkOutput("t5_ovf_rst", ovf, 4'b0000);
      checkOutput("t5_err_rst", {3'b000, gnt_err}, 4'b0000);
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(4'b0001, 4'b0000);
      checkOutput("t5_req_post", req, 4'b0001);
      checkOutput("t5_ack_post", ack, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
